// File: rtl/gateway_recv_pkt.sv
// gateway_recv_pkt: packet-granular receive gateway (sender_id allow-listing, skid-buffered registered output).
// Defining GATEWAY_RECV_STATS_EN adds saturating pass/drop packet counters.
module gateway_recv_pkt #(
  parameter int N_REGIONS = 2,
  parameter int DATA_BITS = 64,
  parameter int DEST_BITS = 14,
  parameter int CNT_BITS  = 32
) (
  input  logic                   i_aclk,
  input  logic                   i_aresetn,
  input  logic [N_REGIONS-1:0]   i_allow_mask,
  input  logic                   i_viol_clr,
  input  logic [DATA_BITS-1:0]   i_s_axis_tdata,
  input  logic [DATA_BITS/8-1:0] i_s_axis_tkeep,
  input  logic                   i_s_axis_tlast,
  input  logic [DEST_BITS-1:0]   i_s_axis_tdest,
  input  logic                   i_s_axis_tvalid,
  output logic                   o_s_axis_tready,
  output logic [DATA_BITS-1:0]   o_m_axis_tdata,
  output logic [DATA_BITS/8-1:0] o_m_axis_tkeep,
  output logic                   o_m_axis_tlast,
  output logic                   o_m_axis_tvalid,
  input  logic                   i_m_axis_tready,
  output logic                   o_viol_sticky,
  output logic [3:0]             o_viol_sender,
  output logic [CNT_BITS-1:0]    o_pass_cnt,
  output logic [CNT_BITS-1:0]    o_drop_cnt
);
  localparam int BW = DATA_BITS + DATA_BITS / 8 + 1;
  typedef enum logic [1:0] {HEAD, PASS, DROP} state_t;
  state_t          r_state, w_state_nx;
  logic [3:0]      w_s;
  logic [15:0]     w_mask;
  logic            w_trusted, w_ok, w_acc, w_head, w_push, w_drop_head;
  logic            w_load, w_pop, w_byp, w_fpush, w_wr1, w_unused;
  logic [1:0]      r_cnt, w_cnt_nx;
  logic [BW-1:0]   w_in, r_sk0, r_sk1, r_out;
  assign w_unused  = ^i_s_axis_tdest;
  assign w_s       = i_s_axis_tdest[9:6];
  assign w_mask    = 16'(i_allow_mask);
  assign w_trusted = int'(w_s) == N_REGIONS || (int'(w_s) >= N_REGIONS + 2 && int'(w_s) <= N_REGIONS + 4);
  assign w_ok      = w_trusted || w_mask[w_s];
  assign w_acc     = i_s_axis_tvalid && o_s_axis_tready;
  assign w_head    = r_state == HEAD;
  assign w_push    = w_acc && (r_state == PASS || (w_head && w_ok));
  assign w_drop_head = w_acc && w_head && !w_ok;
  // Output register refills from the skid head first; an incoming beat bypasses only when the skid is empty.
  assign w_load    = !o_m_axis_tvalid || i_m_axis_tready;
  assign w_pop     = w_load && r_cnt != 2'd0;
  assign w_byp     = w_load && r_cnt == 2'd0 && w_push;
  assign w_fpush   = w_push && !w_byp;
  assign w_wr1     = r_cnt == 2'd2 || (r_cnt == 2'd1 && !w_pop);
  assign w_cnt_nx  = r_cnt + 2'(w_fpush) - 2'(w_pop);
  assign w_in      = {i_s_axis_tlast, i_s_axis_tkeep, i_s_axis_tdata};
  assign {o_m_axis_tlast, o_m_axis_tkeep, o_m_axis_tdata} = r_out;
  always_comb
    w_state_nx = !w_acc ? r_state : i_s_axis_tlast ? HEAD : w_head ? (w_ok ? PASS : DROP) : r_state;
  always_ff @(posedge i_aclk or negedge i_aresetn)
    if (!i_aresetn) begin
      r_state         <= HEAD;
      r_cnt           <= 2'd0;
      r_sk0           <= '0;
      r_sk1           <= '0;
      r_out           <= '0;
      o_m_axis_tvalid <= 1'b0;
      o_s_axis_tready <= 1'b0;
      o_viol_sticky   <= 1'b0;
      o_viol_sender   <= 4'd0;
    end else begin
      r_state         <= w_state_nx;
      r_cnt           <= w_cnt_nx;
      o_s_axis_tready <= w_state_nx == DROP || w_cnt_nx != 2'd2;
      if (w_load) o_m_axis_tvalid <= w_pop || w_byp;
      if (w_pop || w_byp) r_out <= w_pop ? r_sk0 : w_in;
      if (w_pop) r_sk0 <= r_sk1;
      if (w_fpush && !w_wr1) r_sk0 <= w_in;
      if (w_fpush && w_wr1) r_sk1 <= w_in;
      if (w_drop_head) begin
        o_viol_sticky <= 1'b1;
        if (!o_viol_sticky || i_viol_clr) o_viol_sender <= w_s;
      end else if (i_viol_clr) o_viol_sticky <= 1'b0;
    end
`ifdef GATEWAY_RECV_STATS_EN
  always_ff @(posedge i_aclk or negedge i_aresetn)
    if (!i_aresetn) begin
      o_pass_cnt <= '0;
      o_drop_cnt <= '0;
    end else if (w_acc && w_head) begin
      if (w_ok && !(&o_pass_cnt)) o_pass_cnt <= o_pass_cnt + CNT_BITS'(1);
      if (!w_ok && !(&o_drop_cnt)) o_drop_cnt <= o_drop_cnt + CNT_BITS'(1);
    end
`else
  assign o_pass_cnt = '0;
  assign o_drop_cnt = '0;
`endif
endmodule
